// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and the round-robin approach search
// used by the multi-approach traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int MAX_DIR = 8;

  // First requesting approach after cur (wrapping at n); plain cycling when none request.
  function automatic logic [2:0] next_dir(input logic [MAX_DIR-1:0] req,
                                          input logic [2:0]         cur,
                                          input int                 n);
    logic [2:0] idx;
    logic       found;
    idx      = cur;
    found    = 1'b0;
    next_dir = (cur == 3'(n - 1)) ? 3'd0 : cur + 3'd1;
    for (int k = 0; k < MAX_DIR; k++) begin
      if (k < n) begin
        idx = (idx == 3'(n - 1)) ? 3'd0 : idx + 3'd1;
        if (!found && req[idx]) begin
          next_dir = idx;
          found    = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle timing tick every DIV cycles (DIV=1: every cycle).
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-approach round-robin traffic controller with sensor hold/skip and tick timers.
// Define TRAFFIC_PED_WALK_EN to add the pedestrian WALK phase (ped_req / walk ports).
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 2,
  parameter int TICK_DIV     = 1,
  parameter int GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 3
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [NUM_DIR-1:0]         req,
`ifdef TRAFFIC_PED_WALK_EN
  input  logic                       ped_req,
  output logic                       walk,
`endif
  output logic [3*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 phase
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int TW = 16;

  phase_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [DW-1:0]        dir_q, dir_d;
  logic [3*NUM_DIR-1:0] lights_q, lights_d;
  logic [NUM_DIR-1:0]   dir_mask;
  logic [MAX_DIR-1:0]   req_ext;
  logic [DW-1:0]        sel_dir;
  logic                 tick, phase_end, hold, go_walk;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  assign req_ext   = MAX_DIR'(req);
  assign sel_dir   = DW'(next_dir(req_ext, 3'(dir_q), NUM_DIR));
  assign phase_end = tick && (timer_q == '0);
  // Green is held only while the owner is the sole requester.
  assign hold      = (|(req & dir_mask)) && !(|(req & ~dir_mask));

  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_dir
    assign dir_mask[gi] = (dir_q == DW'(gi));
    assign lights_d[3*gi +: 3] = (dir_d != DW'(gi))     ? LAMP_RED :
                                 (state_d == PH_GREEN)  ? LAMP_GRN :
                                 (state_d == PH_YELLOW) ? LAMP_YEL : LAMP_RED;
  end

`ifdef TRAFFIC_PED_WALK_EN
  logic pend_q, pend_d, walk_q, walk_d;

  assign go_walk = pend_q;
  assign walk_d  = (state_d == PH_WALK);
  assign walk    = walk_q;

  always_comb begin
    pend_d = pend_q | ped_req;
    if (phase_end && (state_q == PH_ALLRED) && pend_q) pend_d = ped_req;
  end
`else
  assign go_walk = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    if (tick && (timer_q != '0)) timer_d = timer_q - 1'b1;
    if (phase_end) begin
      unique case (state_q)
        PH_ALLRED: begin
          if (go_walk) begin
            state_d = PH_WALK;
            timer_d = TW'(WALK_TICKS - 1);
          end else begin
            state_d = PH_GREEN;
            timer_d = TW'(GREEN_TICKS - 1);
            dir_d   = sel_dir;
          end
        end
        PH_WALK: begin
          state_d = PH_GREEN;
          timer_d = TW'(GREEN_TICKS - 1);
          dir_d   = sel_dir;
        end
        PH_GREEN: begin
          if (hold) begin
            timer_d = TW'(GREEN_TICKS - 1);
          end else begin
            state_d = PH_YELLOW;
            timer_d = TW'(YELLOW_TICKS - 1);
          end
        end
        PH_YELLOW: begin
          state_d = PH_ALLRED;
          timer_d = TW'(ALLRED_TICKS - 1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= PH_ALLRED;
      timer_q  <= TW'(ALLRED_TICKS - 1);
      dir_q    <= DW'(NUM_DIR - 1);
      lights_q <= {NUM_DIR{LAMP_RED}};
`ifdef TRAFFIC_PED_WALK_EN
      pend_q   <= 1'b0;
      walk_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      dir_q    <= dir_d;
      lights_q <= lights_d;
`ifdef TRAFFIC_PED_WALK_EN
      pend_q   <= pend_d;
      walk_q   <= walk_d;
`endif
    end
  end

  assign lights     = lights_q;
  assign active_dir = dir_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: four parameterisations driven from vector tables
// through an expected-value queue, plus an asynchronous mid-green reset sequence.
`timescale 1ns/1ps
module tb_traffic_ctrl_multi;
  import traffic_pkg::*;

  typedef struct {
    int         sel;     // 0: N=2, 1: N=4, 2: N=3, 3: N=2 with TICK_DIV=3/GREEN=2
    logic [7:0] req;
    logic       ped;
    logic [23:0] lights;
    logic [1:0] phase;
    logic [2:0] dir;
    logic       walk;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [1:0] req2 = '0;
  logic [3:0] req4 = '0;
  logic [2:0] req3 = '0;
  logic [1:0] reqv = '0;
  logic       ped2 = 1'b0;
  logic [5:0]  lights2, lightsv;
  logic [11:0] lights4;
  logic [8:0]  lights3;
  logic        dir2, dirv;
  logic [1:0]  dir4, dir3;
  logic [1:0]  phase2, phase4, phase3, phasev;
  logic        walk2, walk4, walk3, walkv;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  traffic_ctrl_multi #(.NUM_DIR(2)) u_d2 (
    .clk(clk), .clr(clr), .req(req2),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(ped2), .walk(walk2),
`endif
    .lights(lights2), .active_dir(dir2), .phase(phase2));

  traffic_ctrl_multi #(.NUM_DIR(4)) u_d4 (
    .clk(clk), .clr(clr), .req(req4),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(1'b0), .walk(walk4),
`endif
    .lights(lights4), .active_dir(dir4), .phase(phase4));

  traffic_ctrl_multi #(.NUM_DIR(3)) u_d3 (
    .clk(clk), .clr(clr), .req(req3),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(1'b0), .walk(walk3),
`endif
    .lights(lights3), .active_dir(dir3), .phase(phase3));

  traffic_ctrl_multi #(.NUM_DIR(2), .TICK_DIV(3), .GREEN_TICKS(2)) u_div (
    .clk(clk), .clr(clr), .req(reqv),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(1'b0), .walk(walkv),
`endif
    .lights(lightsv), .active_dir(dirv), .phase(phasev));

`ifndef TRAFFIC_PED_WALK_EN
  assign walk2 = 1'b0;
  assign walk4 = 1'b0;
  assign walk3 = 1'b0;
  assign walkv = 1'b0;
`endif

  function automatic int ndir(input int sel);
    case (sel)
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [23:0] all_red(input int n);
    logic [23:0] l = '0;
    for (int i = 0; i < n; i++) l[3*i +: 3] = 3'b100;
    return l;
  endfunction

  function automatic logic [29:0] dut_out(input int sel);
    case (sel)
      0:       return {18'b0, lights2, phase2, 2'b0, dir2, walk2};
      1:       return {12'b0, lights4, phase4, 1'b0, dir4, walk4};
      2:       return {15'b0, lights3, phase3, 1'b0, dir3, walk3};
      default: return {18'b0, lightsv, phasev, 2'b0, dirv, walkv};
    endcase
  endfunction

  task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got lights/phase/dir/walk=%h want=%h", name, got, exp);
    end else begin
      $display("ok   %s lights/phase/dir/walk=%h", name, got);
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] r, input logic p);
    case (sel)
      0:       begin req2 = r[1:0]; ped2 = p; end
      1:       req4 = r[3:0];
      2:       req3 = r[2:0];
      default: reqv = r[1:0];
    endcase
  endtask

  task automatic add_seg(input int sel, input logic [7:0] r, input logic p,
                         input logic [23:0] l, input logic [1:0] ph,
                         input logic [2:0] d, input logic w, input int len);
    vec_t v;
    v.sel = sel; v.req = r; v.ped = p; v.lights = l;
    v.phase = ph; v.dir = d; v.walk = w;
    for (int i = 0; i < len; i++) tbl.push_back(v);
  endtask

  // Each row's inputs are applied before an edge; its expectation is sampled after it.
  task automatic run_table(input string tag);
    int n;
    n = tbl.size();
    for (int i = 0; i < n; i++) begin
      vec_t v;
      vec_t e;
      v = tbl[i];
      drive(v.sel, v.req, v.ped);
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, i), dut_out(e.sel),
            {e.lights, e.phase, e.dir, e.walk});
    end
    tbl.delete();
  endtask

  task automatic reset_and_check(input int sel, input logic [7:0] r, input string tag);
    @(negedge clk);
    req2 = '0; req4 = '0; req3 = '0; reqv = '0; ped2 = 1'b0;
    drive(sel, r, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(tag, dut_out(sel), {all_red(ndir(sel)), 2'd0, 3'(ndir(sel) - 1), 1'b0});
    clr = 1'b1;
  endtask

  task automatic safety(input string name, input logic [23:0] l, input int n);
    int nonred;
    nonred = 0;
    for (int i = 0; i < n; i++) if (l[3*i +: 3] != 3'b100) nonred++;
    checks++;
    if (nonred > 1) begin
      errors++;
      $display("FAIL %s_one_nonred got=%0d non-red triples want<=1 lights=%h", name, nonred, l);
    end
  endtask

  always @(negedge clk) begin
    if (clr) begin
      safety("d2", {18'b0, lights2}, 2);
      safety("d4", {12'b0, lights4}, 4);
      safety("d3", {15'b0, lights3}, 3);
      safety("div", {18'b0, lightsv}, 2);
`ifndef TRAFFIC_PED_WALK_EN
      checks++;
      if (phase2 == 2'd3 || phase4 == 2'd3 || phase3 == 2'd3 || phasev == 2'd3) begin
        errors++;
        $display("FAIL no_walk_phase got phases=%0d,%0d,%0d,%0d want none equal 3",
                 phase2, phase4, phase3, phasev);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // N=2 defaults, no requests: 14-cycle round-robin cycle, run twice.
    reset_and_check(0, 8'h0, "rst_d2");
    for (int rep = 0; rep < 2; rep++) begin
      add_seg(0, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 4);
      add_seg(0, 8'h0, 1'b0, 24'b100_010, PH_YELLOW, 3'd0, 1'b0, 2);
      add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd0, 1'b0, 1);
      add_seg(0, 8'h0, 1'b0, 24'b001_100, PH_GREEN,  3'd1, 1'b0, 4);
      add_seg(0, 8'h0, 1'b0, 24'b010_100, PH_YELLOW, 3'd1, 1'b0, 2);
      add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd1, 1'b0, 1);
    end
    run_table("cycle_d2");

    // Asynchronous reset during the third green cycle, then restart from ALLRED.
    reset_and_check(0, 8'h0, "rst_abort");
    add_seg(0, 8'h0, 1'b0, 24'b100_001, PH_GREEN, 3'd0, 1'b0, 3);
    run_table("pre_abort");
    #2 clr = 1'b0;
    #1 check("async_abort", dut_out(0), {24'b100_100, 2'd0, 3'd1, 1'b0});
    @(negedge clk);
    check("abort_held", dut_out(0), {24'b100_100, 2'd0, 3'd1, 1'b0});
    clr = 1'b1;
    add_seg(0, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 4);
    add_seg(0, 8'h0, 1'b0, 24'b100_010, PH_YELLOW, 3'd0, 1'b0, 2);
    add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd0, 1'b0, 1);
    add_seg(0, 8'h0, 1'b0, 24'b001_100, PH_GREEN,  3'd1, 1'b0, 2);
    run_table("restart");

    // N=4, only dir 3 requesting: skip to 3 and hold; then dir 1 requests.
    reset_and_check(1, 8'b1000, "rst_d4");
    add_seg(1, 8'b1000, 1'b0, 24'b001_100_100_100, PH_GREEN,  3'd3, 1'b0, 12);
    add_seg(1, 8'b1010, 1'b0, 24'b010_100_100_100, PH_YELLOW, 3'd3, 1'b0, 2);
    add_seg(1, 8'b1010, 1'b0, 24'b100_100_100_100, PH_ALLRED, 3'd3, 1'b0, 1);
    add_seg(1, 8'b1010, 1'b0, 24'b100_100_001_100, PH_GREEN,  3'd1, 1'b0, 4);
    add_seg(1, 8'b1010, 1'b0, 24'b100_100_010_100, PH_YELLOW, 3'd1, 1'b0, 2);
    add_seg(1, 8'b1010, 1'b0, 24'b100_100_100_100, PH_ALLRED, 3'd1, 1'b0, 1);
    add_seg(1, 8'b1010, 1'b0, 24'b001_100_100_100, PH_GREEN,  3'd3, 1'b0, 2);
    run_table("hold_d4");

    // N=3, req=101: wrap 2->0, skip 1, wrap again.
    reset_and_check(2, 8'b101, "rst_d3");
    add_seg(2, 8'b101, 1'b0, 24'b100_100_001, PH_GREEN,  3'd0, 1'b0, 4);
    add_seg(2, 8'b101, 1'b0, 24'b100_100_010, PH_YELLOW, 3'd0, 1'b0, 2);
    add_seg(2, 8'b101, 1'b0, 24'b100_100_100, PH_ALLRED, 3'd0, 1'b0, 1);
    add_seg(2, 8'b101, 1'b0, 24'b001_100_100, PH_GREEN,  3'd2, 1'b0, 4);
    add_seg(2, 8'b101, 1'b0, 24'b010_100_100, PH_YELLOW, 3'd2, 1'b0, 2);
    add_seg(2, 8'b101, 1'b0, 24'b100_100_100, PH_ALLRED, 3'd2, 1'b0, 1);
    add_seg(2, 8'b101, 1'b0, 24'b100_100_001, PH_GREEN,  3'd0, 1'b0, 4);
    run_table("wrap_d3");

    // TICK_DIV=3, GREEN_TICKS=2: every phase stretched by 3 clk cycles per tick.
    reset_and_check(3, 8'h0, "rst_div");
    add_seg(3, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd1, 1'b0, 2);
    add_seg(3, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 6);
    add_seg(3, 8'h0, 1'b0, 24'b100_010, PH_YELLOW, 3'd0, 1'b0, 6);
    add_seg(3, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd0, 1'b0, 3);
    add_seg(3, 8'h0, 1'b0, 24'b001_100, PH_GREEN,  3'd1, 1'b0, 6);
    add_seg(3, 8'h0, 1'b0, 24'b010_100, PH_YELLOW, 3'd1, 1'b0, 6);
    add_seg(3, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd1, 1'b0, 3);
    add_seg(3, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 6);
    run_table("div3");

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian pulse in dir-0 green, then a second pulse during the WALK.
    reset_and_check(0, 8'h0, "rst_walk");
    add_seg(0, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 2);
    add_seg(0, 8'h0, 1'b1, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 1);
    add_seg(0, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 1);
    add_seg(0, 8'h0, 1'b0, 24'b100_010, PH_YELLOW, 3'd0, 1'b0, 2);
    add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd0, 1'b0, 1);
    add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_WALK,   3'd0, 1'b1, 2);
    add_seg(0, 8'h0, 1'b1, 24'b100_100, PH_WALK,   3'd0, 1'b1, 1);
    add_seg(0, 8'h0, 1'b0, 24'b001_100, PH_GREEN,  3'd1, 1'b0, 4);
    add_seg(0, 8'h0, 1'b0, 24'b010_100, PH_YELLOW, 3'd1, 1'b0, 2);
    add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_ALLRED, 3'd1, 1'b0, 1);
    add_seg(0, 8'h0, 1'b0, 24'b100_100, PH_WALK,   3'd1, 1'b1, 3);
    add_seg(0, 8'h0, 1'b0, 24'b100_001, PH_GREEN,  3'd0, 1'b0, 4);
    run_table("walk");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
